// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the FSM state encoding, byte-enable constants and a clog2 helper.
package dmem_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam logic [3:0] BE_NONE = 4'h0;
   localparam logic [3:0] BE_WORD = 4'hF;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Masked-priority one-hot picker: lowest set req at index >= ptr, else lowest set req.
// Ports: req (requests), ptr (search start), grant (one-hot, zero when req is zero).
module rr_picker
   import dmem_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic [N-1:0] hi_mask;
   logic [N-1:0] hi_req;

   assign hi_mask = ~((N'(1) << ptr) - N'(1));
   assign hi_req  = req & hi_mask;

   // x & -x isolates the lowest set bit
   assign grant = (hi_req != '0) ? (hi_req & (~hi_req + N'(1)))
                                 : (req & (~req + N'(1)));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates NREQ requesters onto one registered data-memory port, returns read pulses.
// Ports: req_* in / req_ready out, rsp_valid/rsp_rdata out, daddr/dwdata/we/drdata, grant_id.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_lock,
   input  logic [NREQ*AW-1:0]         req_addr,
   input  logic [NREQ*DW-1:0]         req_wdata,
   input  logic [NREQ*(DW/8)-1:0]     req_we,
   output logic [NREQ-1:0]            req_ready,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DW-1:0]              rsp_rdata,
   output logic [AW-1:0]              daddr,
   output logic [DW-1:0]              dwdata,
   output logic [DW/8-1:0]            we,
   input  logic [DW-1:0]              drdata,
   output logic [clog2(NREQ)-1:0]     grant_id
);

   localparam int BW = DW / 8;
   localparam int IW = clog2(NREQ);
   localparam int CW = clog2(MAX_BURST + 1);

   state_t          state;
   state_t          state_n;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] owner_mask;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win_id;
   logic [IW-1:0]   lock_owner;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_wdata;
   logic [BW-1:0]   win_we;
   logic            win_lock;
   logic            accept;
   logic            lock_active;
   logic            lock_eff;
   logic            force_rel;
   logic            lock_hold;
   logic [CW-1:0]   burst_cnt;

   // Lock survives while the owner shows valid or lock; an idle owner releases by dropping lock.
   assign owner_mask = NREQ'(1) << lock_owner;
   assign lock_eff   = lock_active && (((req_valid | req_lock) & owner_mask) != '0);
   assign force_rel  = lock_eff && (burst_cnt >= CW'(MAX_BURST));
   assign lock_hold  = lock_eff && !force_rel;
   assign eligible   = (lock_hold ? (req_valid & owner_mask) : req_valid)
                     & {NREQ{reset}};

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [IW-1:0] rr_ptr;

   assign ptr = rr_ptr;

   always_ff @(posedge clk) begin
      if (!reset)
         rr_ptr <= '0;
      else if (accept)
         rr_ptr <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + IW'(1);
   end
`endif

   rr_picker #(
      .N  (NREQ),
      .PW (IW)
   ) u_pick (
      .req   (eligible),
      .ptr   (ptr),
      .grant (grant)
   );

   always_comb begin
      win_id    = '0;
      win_addr  = '0;
      win_wdata = '0;
      win_we    = '0;
      win_lock  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_id    = IW'(i);
            win_addr  = req_addr[i*AW +: AW];
            win_wdata = req_wdata[i*DW +: DW];
            win_we    = req_we[i*BW +: BW];
            win_lock  = req_lock[i];
         end
      end
   end

   assign accept = |grant;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = accept ? ST_ACCESS : ST_IDLE;
   end

   always_comb begin
      req_ready = grant;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lock_active <= 1'b0;
         lock_owner  <= '0;
         burst_cnt   <= '0;
      end else if (accept) begin
         lock_active <= win_lock;
         lock_owner  <= win_id;
         if (!win_lock)
            burst_cnt <= '0;
         else if (lock_hold)
            burst_cnt <= burst_cnt + CW'(1);
         else
            burst_cnt <= CW'(1);
      end else if (lock_active && !lock_eff) begin
         lock_active <= 1'b0;
         burst_cnt   <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         daddr     <= '0;
         dwdata    <= '0;
         we        <= '0;
         grant_id  <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         if (state == ST_ACCESS) begin
            rsp_valid <= NREQ'(1) << grant_id;
            rsp_rdata <= (we == '0) ? drdata : '0;
         end
         we <= '0;
         if (accept) begin
            daddr    <= win_addr;
            dwdata   <= win_wdata;
            we       <= win_we;
            grant_id <= win_id;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences, random traffic.
// Uses a transaction-level arbitration/memory model to predict grants and responses.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_lock = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_we = '0;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  we;
   logic [31:0] drdata;
   logic [0:0]  grant_id;

   int checks = 0;
   int failures = 0;

   dmem_arbiter #(
      .NREQ(2), .AW(32), .DW(32), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // environment memory: clocked byte write, combinational read
   logic [31:0] dmem [32];
   assign drdata = dmem[daddr[6:2]];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (we[b]) dmem[daddr[6:2]][b*8 +: 8] <= dwdata[b*8 +: 8];
   end

   // reference model state
   typedef struct {
      bit          v;
      int          id;
      logic [31:0] data;
      logic [31:0] addr;
      logic [3:0]  be;
   } exp_t;

   logic [31:0] m_mem [32];
   int   m_last;
   int   m_owner;
   int   m_run;
   exp_t st1;
   exp_t st2;
   logic [1:0]  obs_rv;
   logic [31:0] obs_rd;
   logic [1:0]  obs_rdy;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_last  = 1;
      m_owner = -1;
      m_run   = 0;
      st1.v   = 0;
      st2.v   = 0;
   endtask

   task automatic do_reset(input int n, input logic [1:0] v);
      rst_n     = 1'b0;
      req_valid = v;
      req_lock  = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("rst_ready", {30'd0, req_ready}, 32'd0);
         if (k >= 1) begin
            chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            chk("rst_we", {28'd0, we}, 32'd0);
         end
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic step(input logic [1:0] v, input logic [1:0] l,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] w0, input logic [3:0] w1);
      int w;
      int start;
      bit forced;
      logic [31:0] aw;
      logic [31:0] dw;
      logic [3:0]  bw;
      logic [1:0]  exp_rdy;
      req_valid = v;
      req_lock  = l;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
      req_we    = {w1, w0};
      @(negedge clk);
      // idle owner that also drops lock gives up the lock this cycle
      if (m_owner >= 0 && !v[m_owner] && !l[m_owner]) begin
         m_owner = -1;
         m_run   = 0;
      end
      forced = (m_owner >= 0) && (m_run >= MAXB);
      w = -1;
      if (m_owner >= 0 && !forced) begin
         if (v[m_owner]) w = m_owner;
      end else begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         start = 0;
`else
         start = (m_last + 1) % 2;
`endif
         for (int k = 0; k < 2; k++)
            if (w < 0 && v[(start + k) % 2]) w = (start + k) % 2;
      end
      exp_rdy = (w >= 0) ? (2'b01 << w) : 2'b00;
      chk("ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      chk("rsp_valid", {30'd0, rsp_valid},
          st2.v ? (32'd1 << st2.id) : 32'd0);
      if (st2.v) chk("rsp_rdata", rsp_rdata, st2.data);
      chk("we_port", {28'd0, we}, st1.v ? {28'd0, st1.be} : 32'd0);
      if (st1.v) begin
         chk("grant_id", {31'd0, grant_id}, st1.id);
         chk("daddr", daddr, st1.addr);
      end
      obs_rv  = rsp_valid;
      obs_rd  = rsp_rdata;
      obs_rdy = req_ready;
      st2   = st1;
      st1.v = 0;
      if (w >= 0) begin
         aw = (w == 0) ? a0 : a1;
         dw = (w == 0) ? d0 : d1;
         bw = (w == 0) ? w0 : w1;
         for (int b = 0; b < 4; b++)
            if (bw[b]) m_mem[aw[6:2]][b*8 +: 8] = dw[b*8 +: 8];
         st1.v    = 1;
         st1.id   = w;
         st1.addr = aw;
         st1.be   = bw;
         st1.data = (bw != BE_NONE) ? 32'd0 : m_mem[aw[6:2]];
         if (l[w]) begin
            m_run = (m_owner == w && !forced) ? m_run + 1 : 1;
            m_owner = w;
         end else begin
            m_owner = -1;
            m_run   = 0;
         end
         m_last = w;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(2'b00, 2'b00, 0, 0, 0, 0, BE_NONE, BE_NONE);
   endtask

   typedef struct {
      bit         rst_before;
      logic [1:0] v;
      logic [1:0] l;
      logic [1:0] exp;
   } vec_t;

   vec_t tbl [16];

   initial begin
      logic [3:0]  rw0;
      logic [3:0]  rw1;
      int          r;
      // grants alternate under contention, then a locked burst of 4 from req1
      tbl[0]  = '{1, 2'b11, 2'b00, 2'b01};
      tbl[1]  = '{0, 2'b11, 2'b00, 2'b10};
      tbl[2]  = '{0, 2'b11, 2'b00, 2'b01};
      tbl[3]  = '{0, 2'b11, 2'b00, 2'b10};
      tbl[4]  = '{0, 2'b11, 2'b00, 2'b01};
      tbl[5]  = '{0, 2'b11, 2'b00, 2'b10};
      tbl[6]  = '{1, 2'b01, 2'b00, 2'b01};
      tbl[7]  = '{0, 2'b11, 2'b10, 2'b10};
      tbl[8]  = '{0, 2'b11, 2'b10, 2'b10};
      tbl[9]  = '{0, 2'b11, 2'b10, 2'b10};
      tbl[10] = '{0, 2'b11, 2'b10, 2'b10};
      tbl[11] = '{0, 2'b11, 2'b10, 2'b01};
      tbl[12] = '{0, 2'b11, 2'b10, 2'b10};
      tbl[13] = '{0, 2'b11, 2'b00, 2'b10};
      tbl[14] = '{0, 2'b11, 2'b00, 2'b01};
      tbl[15] = '{0, 2'b11, 2'b00, 2'b10};
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 16; i++) tbl[i].exp = 2'b01;
`endif
      model_clear();
      @(posedge clk);
      #1;

      // reset with both valid, then first grant and its response
      do_reset(3, 2'b11);
      step(2'b11, 2'b00, 32'h0, 32'h4, 32'h5, 32'h6, BE_WORD, BE_WORD);
      chk("t1_ready", {30'd0, obs_rdy}, 32'd1);
      idle();
      idle();
      chk("t1_rsp", {30'd0, obs_rv}, 32'd1);

      // preload every word so later reads are defined
      for (int i = 0; i < 32; i++)
         step(2'b01, 2'b00, i * 4, 0, 32'hA5000000 + i, 0, BE_WORD, BE_NONE);

      // write then read same address back to back
      step(2'b01, 2'b00, 32'h10, 0, 32'hDEADBEEF, 0, BE_WORD, BE_NONE);
      step(2'b01, 2'b00, 32'h10, 0, 0, 0, BE_NONE, BE_NONE);
      idle();
      chk("t2_wr_rdata", obs_rd, 32'h0);
      idle();
      chk("t2_rd_valid", {30'd0, obs_rv}, 32'd1);
      chk("t2_rd_rdata", obs_rd, 32'hDEADBEEF);

      // table of arbitration vectors
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].rst_before) do_reset(1, 2'b11);
         step(tbl[i].v, tbl[i].l, 32'h40 + i * 4, 32'h40 + i * 4,
              0, 0, BE_NONE, BE_NONE);
         chk($sformatf("tbl_ready_%0d", i), {30'd0, obs_rdy},
             {30'd0, tbl[i].exp});
      end
      idle();
      idle();

      // byte-lane write merge
      step(2'b01, 2'b00, 32'h20, 0, 32'h11111111, 0, BE_WORD, BE_NONE);
      step(2'b01, 2'b00, 32'h20, 0, 32'h0000AB00, 0, 4'b0010, BE_NONE);
      step(2'b01, 2'b00, 32'h20, 0, 0, 0, BE_NONE, BE_NONE);
      idle();
      idle();
      chk("t5_rdata", obs_rd, 32'h1111AB11);

      // reset the cycle after an accept drops the response
      step(2'b01, 2'b00, 32'h30, 0, 32'h12345678, 0, BE_WORD, BE_NONE);
      do_reset(2, 2'b00);
      idle();
      chk("t6_no_rsp", {30'd0, obs_rv}, 32'd0);

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1 + $urandom_range(0, 1), 2'($urandom));
         end else begin
            r   = $urandom_range(0, 3);
            rw0 = (r == 0) ? BE_WORD : (r == 1) ? 4'($urandom) : BE_NONE;
            r   = $urandom_range(0, 3);
            rw1 = (r == 0) ? BE_WORD : (r == 1) ? 4'($urandom) : BE_NONE;
            step(2'($urandom),
                 {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                 {25'd0, 5'($urandom), 2'b00}, {25'd0, 5'($urandom), 2'b00},
                 $urandom, $urandom, rw0, rw1);
         end
      end
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
